imem_loader: RTL

- Writer side of the 8-bit instruction memory: receives a program image as a byte stream over a valid/ready handshake and drives the memory write port.
- Writes the image from address 0 upward, checks an 8-bit checksum, then fills every remaining location with NOP (8'hF0).
- Holds the CPU in reset until a good image is resident.
- Sits between the host/boot byte source and the instruction memory; the core fetch path keeps its read port.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave view; the host/boot source and memory take the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length/data/checksum byte stream into instruction memory, pads the rest
// with NOPs and keeps the CPU held in reset until a verified image is resident.
module imem_loader #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  imem_loader_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       cpu_hold
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_FILL,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  n_len;
  logic [7:0]        sum;
  logic [7:0]        csum_total;
  logic              xfer;
  logic              last_data;
  logic              fill_end;

  logic              in_ready_d;
  logic              busy_d;
  logic              done_d;
  logic              error_d;
  logic              cpu_hold_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  assign xfer       = bus.in_valid & bus.in_ready;
  assign last_data  = ((count + CNT_W'(1)) == n_len);
  assign csum_total = sum + bus.in_data;
  // The extra counter bit marks "all 2^ADDR_W locations covered" without wrapping.
  assign fill_end   = count[ADDR_W];

  // State register; every status output and the write port are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
    end else begin
      state        <= next_state;
      bus.in_ready <= in_ready_d;
      bus.wr_en    <= wr_en_d;
      bus.wr_addr  <= wr_addr_d;
      bus.wr_data  <= wr_data_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      cpu_hold     <= cpu_hold_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state = S_LEN;
      end
      S_LEN: begin
        if (xfer) next_state = S_DATA;
      end
      S_DATA: begin
        if (xfer && last_data) next_state = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) begin
          if (csum_total != 8'h00) next_state = S_ERR;
          else if (n_len[ADDR_W])  next_state = S_DONE;
          else                     next_state = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_end) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it after the edge.
  always_comb begin
    in_ready_d = (next_state == S_LEN) || (next_state == S_DATA) || (next_state == S_CSUM);
    busy_d     = in_ready_d || (next_state == S_FILL);
    done_d     = (next_state == S_DONE);
    error_d    = (next_state == S_ERR);
    cpu_hold_d = (next_state != S_DONE);
    wr_en_d    = 1'b0;
    wr_addr_d  = bus.wr_addr;
    wr_data_d  = bus.wr_data;
    if ((state == S_DATA) && xfer) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count[ADDR_W-1:0];
      wr_data_d = DATA_W'(bus.in_data);
    end else if ((state == S_FILL) && !fill_end) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count[ADDR_W-1:0];
      wr_data_d = NOP_WORD;
    end
  end

  // Length, address counter and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      n_len <= '0;
      sum   <= 8'h00;
    end else begin
      case (state)
        S_LEN: begin
          if (xfer) begin
            n_len <= (bus.in_data == 8'h00) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(bus.in_data);
            count <= '0;
            sum   <= 8'h00;
          end
        end
        S_DATA: begin
          if (xfer) begin
            count <= count + CNT_W'(1);
            sum   <= sum + bus.in_data;
          end
        end
        S_FILL: begin
          if (!fill_end) count <= count + CNT_W'(1);
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule
